// File: rtl/time_set_ctrl.sv
//==============================================================================
// Module      : time_set_ctrl
// Description : Clock/alarm mode controller with registered adjust pulses and a
//               self-cancelling alarm; optional snooze state under `SNOOZE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module time_set_ctrl #(
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       alarm_match,
    output logic       sec_en,
    output logic       thr_adj,
    output logic       tmin_adj,
    output logic       ahr_adj,
    output logic       amin_adj,
    output logic       adj_dec,
    output logic [2:0] state,
    output logic       alarm_armed,
    output logic       blink,
    output logic       buzzer
);

    localparam logic [2:0] c_run      = 3'd0;
    localparam logic [2:0] c_set_thr  = 3'd1;
    localparam logic [2:0] c_set_tmin = 3'd2;
    localparam logic [2:0] c_set_ahr  = 3'd3;
    localparam logic [2:0] c_set_amin = 3'd4;
    localparam logic [2:0] c_ring     = 3'd5;
    localparam logic [2:0] c_snooze   = 3'd6;

    localparam int c_max_ticks = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int c_cnt_w     = $clog2(c_max_ticks + 1);
    localparam logic [c_cnt_w-1:0] c_ring_last = c_cnt_w'(RING_TICKS - 1);
`ifdef SNOOZE_EN
    localparam logic [c_cnt_w-1:0] c_snz_last  = c_cnt_w'(SNOOZE_TICKS - 1);
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_d;
    logic               r_match_d;
    logic               r_sec_en;
    logic [3:0]         r_adj;
    logic [3:0]         w_adj;
    logic               r_dec;
    logic               w_dec_d;
    logic               r_armed;
    logic               w_armed_d;
    logic               r_blink;
    logic               w_blink_d;
    logic               r_buzz;
    logic               w_buzz_d;
    logic               w_sec_en_d;

    // Mode wins over up/down, and up+down together cancel out.
    logic w_adj_req;
    logic w_rise;
    logic w_in_set;
    logic w_next_set;
    logic w_ring_exit;
    logic w_ring_timeout;

    assign w_adj_req      = (btn_up ^ btn_down) & ~btn_mode;
    assign w_rise         = alarm_match & ~r_match_d;
    assign w_in_set       = (r_state >= c_set_thr) && (r_state <= c_set_amin);
    assign w_next_set     = (w_next >= c_set_thr) && (w_next <= c_set_amin);
    assign w_ring_timeout = tick_1hz && (r_cnt == c_ring_last);
`ifdef SNOOZE_EN
    assign w_ring_exit    = btn_mode | btn_up;
`else
    assign w_ring_exit    = btn_mode | btn_up | btn_down;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_run;
            r_cnt     <= '0;
            r_match_d <= 1'b1;
            r_sec_en  <= 1'b0;
            r_adj     <= 4'b0000;
            r_dec     <= 1'b0;
            r_armed   <= 1'b0;
            r_blink   <= 1'b0;
            r_buzz    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_d;
            r_match_d <= alarm_match;
            r_sec_en  <= w_sec_en_d;
            r_adj     <= w_adj;
            r_dec     <= w_dec_d;
            r_armed   <= w_armed_d;
            r_blink   <= w_blink_d;
            r_buzz    <= w_buzz_d;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_run: begin
                if (btn_mode)
                    w_next = c_set_thr;
                else if (r_armed && w_rise)
                    w_next = c_ring;
            end
            c_set_thr:  if (btn_mode) w_next = c_set_tmin;
            c_set_tmin: if (btn_mode) w_next = c_set_ahr;
            c_set_ahr:  if (btn_mode) w_next = c_set_amin;
            c_set_amin: if (btn_mode) w_next = c_run;
            c_ring: begin
                if (w_ring_exit)
                    w_next = c_run;
`ifdef SNOOZE_EN
                else if (btn_down)
                    w_next = c_snooze;
`endif
                else if (w_ring_timeout)
                    w_next = c_run;
            end
`ifdef SNOOZE_EN
            c_snooze: begin
                if (btn_mode || btn_up)
                    w_next = c_run;
                else if (tick_1hz && (r_cnt == c_snz_last))
                    w_next = c_ring;
            end
`endif
            default: w_next = c_run;
        endcase
    end

    always_comb begin
        w_adj = 4'b0000;
        if (w_adj_req) begin
            case (r_state)
                c_set_thr:  w_adj = 4'b1000;
                c_set_tmin: w_adj = 4'b0100;
                c_set_ahr:  w_adj = 4'b0010;
                c_set_amin: w_adj = 4'b0001;
                default:    w_adj = 4'b0000;
            endcase
        end
        w_dec_d    = (|w_adj) & btn_down;
        w_sec_en_d = tick_1hz & ~w_next_set;
        w_armed_d  = r_armed ^ ((r_state == c_run) & w_adj_req & btn_up);
        w_buzz_d   = (w_next == c_ring);

        if (w_next == c_run)
            w_blink_d = 1'b0;
        else if (w_in_set && tick_1hz)
            w_blink_d = ~r_blink;
        else
            w_blink_d = r_blink;

        // Any state change clears the tick count, so every RING/SNOOZE entry starts at zero.
        if (w_next != r_state)
            w_cnt_d = '0;
        else if (tick_1hz && ((r_state == c_ring) || (r_state == c_snooze)))
            w_cnt_d = r_cnt + c_cnt_w'(1);
        else
            w_cnt_d = r_cnt;
    end

    assign state       = r_state;
    assign sec_en      = r_sec_en;
    assign thr_adj     = r_adj[3];
    assign tmin_adj    = r_adj[2];
    assign ahr_adj     = r_adj[1];
    assign amin_adj    = r_adj[0];
    assign adj_dec     = r_dec;
    assign alarm_armed = r_armed;
    assign blink       = r_blink;
    assign buzzer      = r_buzz;

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
//==============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed scoreboard bench for time_set_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, alarm_match = 1'b0;
    logic sec_en, thr_adj, tmin_adj, ahr_adj, amin_adj, adj_dec, alarm_armed, blink, buzzer;
    logic [2:0] state;

    time_set_ctrl #(.RING_TICKS(60), .SNOOZE_TICKS(300)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .alarm_match(alarm_match), .sec_en(sec_en),
        .thr_adj(thr_adj), .tmin_adj(tmin_adj), .ahr_adj(ahr_adj), .amin_adj(amin_adj),
        .adj_dec(adj_dec), .state(state), .alarm_armed(alarm_armed),
        .blink(blink), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    // Input vector order: {mode, up, down, tick, match}
    localparam logic [4:0] I_MODE = 5'b10000;
    localparam logic [4:0] I_UP   = 5'b01000;
    localparam logic [4:0] I_DOWN = 5'b00100;
    localparam logic [4:0] I_TICK = 5'b00010;
    localparam logic [4:0] I_M    = 5'b00001;
    localparam logic [11:0] M_ALL   = 12'hFFF;
    localparam logic [11:0] M_NODEC = 12'hFF7;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        logic [11:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int ncyc     = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] dut_out;
    assign dut_out = {state, sec_en, thr_adj, tmin_adj, ahr_adj, amin_adj,
                      adj_dec, alarm_armed, blink, buzzer};

    function automatic logic [11:0] ev(input logic [2:0] st, input logic sec,
                                       input logic [3:0] adj, input logic dec,
                                       input logic arm, input logic blk, input logic bz);
        return {st, sec, adj, dec, arm, blk, bz};
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic [4:0] v, input string nm,
                       input logic [11:0] e, input logic [11:0] m);
        exp_t x;
        @(negedge clk);
        {btn_mode, btn_up, btn_down, tick_1hz, alarm_match} = v;
        x.cyc  = ncyc + 1;
        x.exp  = e;
        x.mask = m;
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            ncyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
                exp_t x;
                x = sb.pop_front();
                n_checks++;
                if ((dut_out & x.mask) !== (x.exp & x.mask)) begin
                    n_errors++;
                    $display("FAIL %s @cycle %0d: got %h expected %h (mask %h)",
                             x.name, ncyc, dut_out, x.exp, x.mask);
                end
            end
        end
    end

    initial begin
        logic [11:0] z;
        z = 12'h000;

        cyc(5'b0, "reset0", z, M_ALL);
        cyc(5'b0, "reset1", z, M_ALL);
        rst = 1'b1;

        cyc(I_MODE,          "mode->thr",   ev(1,0,4'h0,0,0,0,0), M_ALL);
        cyc(I_TICK,          "thr tick",    ev(1,0,4'h0,0,0,1,0), M_ALL);
        cyc(I_MODE,          "mode->tmin",  ev(2,0,4'h0,0,0,1,0), M_ALL);
        cyc(I_MODE | I_TICK, "mode->ahr",   ev(3,0,4'h0,0,0,0,0), M_ALL);
        cyc(I_MODE,          "mode->amin",  ev(4,0,4'h0,0,0,0,0), M_ALL);
        cyc(I_TICK,          "amin tick",   ev(4,0,4'h0,0,0,1,0), M_ALL);
        cyc(I_MODE,          "mode->run",   ev(0,0,4'h0,0,0,0,0), M_ALL);
        cyc(I_TICK,          "run tick",    ev(0,1,4'h0,0,0,0,0), M_ALL);
        cyc(5'b0,            "run idle",    ev(0,0,4'h0,0,0,0,0), M_ALL);

        cyc(I_MODE,          "to thr",      ev(1,0,4'h0,0,0,0,0), M_ALL);
        cyc(I_UP,            "thr up",      ev(1,0,4'b1000,0,0,0,0), M_ALL);
        cyc(I_MODE,          "to tmin",     ev(2,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_UP,            "tmin up",     ev(2,0,4'b0100,0,0,0,0), M_ALL);
        cyc(I_DOWN,          "tmin down",   ev(2,0,4'b0100,1,0,0,0), M_ALL);
        cyc(5'b0,            "tmin idle",   ev(2,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_UP | I_DOWN,   "up+down",     ev(2,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_MODE | I_UP,   "mode+up",     ev(3,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_DOWN,          "ahr down",    ev(3,0,4'b0010,1,0,0,0), M_ALL);
        cyc(I_MODE,          "to amin",     ev(4,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_UP,            "amin up",     ev(4,0,4'b0001,0,0,0,0), M_ALL);
        cyc(I_MODE | I_DOWN, "mode+down",   ev(0,0,4'h0,0,0,0,0), M_NODEC);

        cyc(I_DOWN,          "run down",    ev(0,0,4'h0,0,0,0,0), M_NODEC);
        cyc(I_UP,            "arm",         ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ring",        ev(5,0,4'h0,0,1,0,1), M_NODEC);
        cyc(I_M,             "ring hold",   ev(5,0,4'h0,0,1,0,1), M_NODEC);
        cyc(I_MODE | I_M,    "dismiss",     ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "no rering a", ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "no rering b", ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(5'b0,            "match low",   ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ring2",       ev(5,0,4'h0,0,1,0,1), M_NODEC);
        for (int i = 1; i <= 60; i++) begin
            cyc(I_TICK | I_M, $sformatf("timeout tick%0d", i),
                (i < 60) ? ev(5,1,4'h0,0,1,0,1) : ev(0,1,4'h0,0,1,0,0), M_NODEC);
            if (i < 60)
                cyc(I_M, "ring gap", ev(5,0,4'h0,0,1,0,1), M_NODEC);
        end
        cyc(I_M,             "after timeout", ev(0,0,4'h0,0,1,0,0), M_NODEC);

        cyc(5'b0,            "drop3",       ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ring3",       ev(5,0,4'h0,0,1,0,1), M_NODEC);
        for (int i = 1; i <= 59; i++)
            cyc(I_TICK | I_M, $sformatf("ring3 tick%0d", i), ev(5,1,4'h0,0,1,0,1), M_NODEC);
        cyc(I_TICK | I_MODE | I_M, "btn at timeout", ev(0,1,4'h0,0,1,0,0), M_NODEC);

        cyc(5'b0,            "drop4",       ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ring4",       ev(5,0,4'h0,0,1,0,1), M_NODEC);
`ifdef SNOOZE_EN
        cyc(I_DOWN | I_M,    "snooze",      ev(6,0,4'h0,0,1,0,0), M_NODEC);
        for (int i = 1; i <= 300; i++)
            cyc(I_TICK | I_M, $sformatf("snooze tick%0d", i),
                (i < 300) ? ev(6,1,4'h0,0,1,0,0) : ev(5,1,4'h0,0,1,0,1), M_NODEC);
        cyc(I_UP | I_M,      "ring up",     ev(0,0,4'h0,0,1,0,0), M_NODEC);
`else
        cyc(I_DOWN | I_M,    "ring down",   ev(0,0,4'h0,0,1,0,0), M_NODEC);
`endif

        cyc(5'b0,            "drop5",       ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_MODE,          "r to thr",    ev(1,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_MODE,          "r to tmin",   ev(2,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_MODE,          "r to ahr",    ev(3,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ahr match",   ev(3,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_UP | I_M,      "reset mid-set", z, M_ALL);
        rst = 1'b0;
        cyc(I_M,             "reset release", z, M_ALL);
        rst = 1'b1;
        cyc(I_UP | I_M,      "rearm",       ev(0,0,4'h0,0,1,0,0), M_ALL);
        cyc(I_M,             "held a",      ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "held b",      ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(5'b0,            "drop6",       ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(I_M,             "ring6",       ev(5,0,4'h0,0,1,0,1), M_NODEC);
        cyc(I_MODE,          "final dismiss", ev(0,0,4'h0,0,1,0,0), M_NODEC);
        cyc(5'b0,            "final idle",  ev(0,0,4'h0,0,1,0,0), M_NODEC);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
